// File: rtl/cts_pipe.sv
// Current-time-stamp counter built from carry-pipelined SW-bit segments, with
// software load, wrap pulse and CN sticky trigger-capture channels.
module cts_pipe #(
    parameter int unsigned TW = 64,
    parameter int unsigned SW = 16,
    parameter int unsigned CN = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             ld,
    input  logic [TW-1:0]    ld_val,
    output logic [TW-1:0]    cts,
    output logic             wrap,
    input  logic [CN-1:0]    cap_trg,
    input  logic [CN-1:0]    cap_ack,
    output logic [CN*TW-1:0] cap_ts,
    output logic [CN-1:0]    cap_vld,
    output logic [CN-1:0]    cap_ovf
);

    localparam int unsigned NSEG = TW / SW;
    localparam int unsigned LAT  = NSEG - 1;

    logic [NSEG-1:0] seg_ld;
    logic [NSEG-1:0] seg_cin;
    logic [TW-1:0]   seg_ldv;
    logic [TW-1:0]   seg_q;
    logic            wrap_q;

    // Segment k holds bits of the ideal count as it stood k cycles ago, so the
    // load strobe and value are delayed by k to stay coherent with the carry.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SW-1:0] q;

        if (k == 0) begin : g_head
            assign seg_ld[0]          = ld;
            assign seg_ldv[SW-1:0]    = ld_val[SW-1:0];
            assign seg_cin[0]         = en;
        end else begin : g_tail
            logic          ldd  [1:k];
            logic [SW-1:0] ldvd [1:k];
            logic          cr;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int unsigned j = 1; j <= k; j++) begin
                        ldd[j]  <= 1'b0;
                        ldvd[j] <= '0;
                    end
                    cr <= 1'b0;
                end else begin
                    ldd[1]  <= ld;
                    ldvd[1] <= ld_val[k*SW +: SW];
                    for (int unsigned j = 2; j <= k; j++) begin
                        ldd[j]  <= ldd[j-1];
                        ldvd[j] <= ldvd[j-1];
                    end
                    cr <= ~seg_ld[k-1] & seg_cin[k-1] & (&seg_q[(k-1)*SW +: SW]);
                end
            end

            assign seg_ld[k]           = ldd[k];
            assign seg_ldv[k*SW +: SW] = ldvd[k];
            assign seg_cin[k]          = cr;
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                q <= '0;
            end else if (seg_ld[k]) begin
                q <= seg_ldv[k*SW +: SW];
            end else begin
                q <= q + SW'(seg_cin[k]);
            end
        end

        assign seg_q[k*SW +: SW] = q;

        if (k < LAT) begin : g_skew
            localparam int unsigned D = LAT - k;
            logic [SW-1:0] sk [1:D];

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int unsigned j = 1; j <= D; j++) begin
                        sk[j] <= '0;
                    end
                end else begin
                    sk[1] <= q;
                    for (int unsigned j = 2; j <= D; j++) begin
                        sk[j] <= sk[j-1];
                    end
                end
            end

            assign cts[k*SW +: SW] = sk[D];
        end else begin : g_noskew
            assign cts[k*SW +: SW] = q;
        end
    end

    // Top segment carry-out is the full-width overflow, already output-aligned.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= ~seg_ld[LAT] & seg_cin[LAT] & (&seg_q[LAT*SW +: SW]);
        end
    end

    assign wrap = wrap_q;

    for (genvar c = 0; c < CN; c++) begin : g_cap
        logic [TW-1:0] ts;
        logic          v;
        logic          o;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                ts <= '0;
                v  <= 1'b0;
                o  <= 1'b0;
            end else if (cap_trg[c] && (!v || cap_ack[c])) begin
                ts <= cts;
                v  <= 1'b1;
                if (cap_ack[c]) begin
                    o <= 1'b0;
                end
            end else if (cap_trg[c]) begin
                o <= 1'b1;
            end else if (cap_ack[c]) begin
                v <= 1'b0;
                o <= 1'b0;
            end
        end

        assign cap_ts[c*TW +: TW] = ts;
        assign cap_vld[c]         = v;
        assign cap_ovf[c]         = o;
    end

endmodule
